// File: rtl/led_count_bank.sv
`default_nettype none
// led_count_bank: NCH programmable up-counters (wrap or one-shot) behind one
// command port, with a registered LED tap showing a slice of a selected channel.
module led_count_bank #(
  parameter int WIDTH   = 32,
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int LED_W   = 8,
  parameter int LED_LSB = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CHW-1:0]     cmd_ch,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  output logic               cmd_err,
  input  logic [CHW-1:0]     led_sel,
  output logic [LED_W-1:0]   led,
  output logic [NCH-1:0]     run,
  output logic [NCH-1:0]     done,
  output logic [NCH-1:0]     wrap
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD_CNT = 2'b00;
  localparam logic [1:0] OP_LOAD_LIM = 2'b01;
  localparam logic [1:0] OP_START    = 2'b10;
  localparam logic [1:0] OP_STOP     = 2'b11;

  logic [WIDTH-1:0] count   [NCH];
  logic [WIDTH-1:0] limit   [NCH];
  logic             oneshot [NCH];
  state_t           state   [NCH];

  logic             accept;
  logic [NCH-1:0]   hit;
  logic             ch_ok;
  logic [LED_W-1:0] led_next;

  assign accept = cmd_valid && cmd_ready;

  // Channel decode by comparison so indices >= NCH never address the arrays.
  always_comb begin
    hit      = '0;
    ch_ok    = 1'b0;
    led_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cmd_ch == CHW'(i)) begin
        hit[i] = accept;
        ch_ok  = 1'b1;
      end
      if (led_sel == CHW'(i)) begin
        led_next = count[i][LED_LSB +: LED_W];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmd_ready <= 1'b1;
      cmd_err   <= 1'b0;
      led       <= '0;
      done      <= '0;
      wrap      <= '0;
      for (int i = 0; i < NCH; i++) begin
        count[i]   <= '0;
        limit[i]   <= '1;
        oneshot[i] <= 1'b0;
        state[i]   <= S_IDLE;
      end
    end else begin
      cmd_ready <= !accept;
      cmd_err   <= accept && !ch_ok;
      led       <= led_next;
      for (int i = 0; i < NCH; i++) begin
        done[i] <= 1'b0;
        wrap[i] <= 1'b0;
        // An accepted command owns the channel this cycle; the increment is dropped.
        if (hit[i]) begin
          case (cmd_op)
            OP_LOAD_CNT: count[i] <= cmd_data;
            OP_LOAD_LIM: limit[i] <= cmd_data;
            OP_START: begin
              if (state[i] == S_DONE) begin
                count[i] <= '0;
              end
              oneshot[i] <= cmd_data[0];
              state[i]   <= S_RUN;
            end
            OP_STOP: begin
              count[i] <= '0;
              state[i] <= S_IDLE;
            end
          endcase
        end else if (enable && state[i] == S_RUN) begin
          if (count[i] == limit[i]) begin
            if (oneshot[i]) begin
              state[i] <= S_DONE;
              done[i]  <= 1'b1;
            end else begin
              count[i] <= '0;
              wrap[i]  <= 1'b1;
            end
          end else begin
            count[i] <= count[i] + 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_run
    assign run[g] = (state[g] == S_RUN);
  end

endmodule
`default_nettype wire
